instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/if_outreg.sv | 52 +++++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/address widths, opcode constants and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BGT  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Opcode lives in the top nibble of every instruction word.
  function automatic logic is_op(input logic [INSTR_W-1:0] instr, input logic [3:0] op);
    return instr[INSTR_W-1:INSTR_W-4] == op;
  endfunction

endpackage

// File: rtl/if_outreg.sv
// Fetch output register: holds one instruction for decode and keeps it stable
// until decode accepts it; a flush empties the slot.
module if_outreg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_jmp,
  input  logic               i_ready,
  output logic               o_can_load,
  output logic               o_stall,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_jmp_taken
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_jmp;

  // The slot may be refilled when empty or when its word is consumed this edge.
  assign o_can_load = !r_valid || i_ready;
  assign o_stall    = r_valid && !i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_jmp   <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_jmp   <= i_jmp;
    end
  end

  assign o_valid     = r_valid;
  assign o_instr     = r_instr;
  assign o_pc        = r_pc;
  assign o_jmp_taken = r_jmp;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, next-PC selection with jmp predecode, and the
// IDLE/RUN/HOLD control FSM driving a combinational instruction ROM.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]        JMP_OP   = 4'b1110
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_oe,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_jmp_taken
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;

  logic              w_running;
  logic              w_can_load;
  logic              w_stall;
  logic              w_load;
  logic              w_flush;
  logic              w_is_jmp;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_running = (r_state != ST_IDLE);
  assign w_is_jmp  = is_op(rom_data, JMP_OP);
  assign w_next_pc = w_is_jmp ? {4'h0, rom_data[11:0]} : r_pc + 16'd1;

  // A taken branch from downstream wins over both loading and holding.
  assign w_flush = w_running && redirect_valid;
  assign w_load  = w_running && w_can_load && !redirect_valid;

  assign rom_addr = r_pc;
  assign rom_oe   = w_running;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else if (r_state == ST_IDLE) begin
      r_state <= ST_RUN;
    end else if (redirect_valid) begin
      r_state <= ST_RUN;
      r_pc    <= redirect_pc;
    end else begin
      if (w_load) begin
        r_pc <= w_next_pc;
      end
      r_state <= w_stall ? ST_HOLD : ST_RUN;
    end
  end

  if_outreg u_outreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_flush     (w_flush),
    .i_instr     (rom_data),
    .i_pc        (r_pc),
    .i_jmp       (w_is_jmp),
    .i_ready     (if_ready),
    .o_can_load  (w_can_load),
    .o_stall     (w_stall),
    .o_valid     (if_valid),
    .o_instr     (if_instr),
    .o_pc        (if_pc),
    .o_jmp_taken (if_jmp_taken)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a stream-level fetch model checked every
// cycle, literal spot checks, and a check of the accepted-instruction stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic        rom_oe;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_jmp_taken;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] acc_q[$];

  // Model of what fetch must be presenting after each edge.
  logic        m_known = 1'b0;
  logic        m_started, m_valid, m_jmp;
  logic [15:0] m_pc, m_instr, m_ipc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_oe         (rom_oe),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_jmp_taken   (if_jmp_taken)
  );

  // ROM image: word 9 is "jmp 4", every other word is a non-jmp tagged by address.
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'd9) return 16'hE004;
    return {4'h1, a[11:0]};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic rdy, input logic redir,
                            input logic [15:0] rpc);
    logic [15:0] w;
    if (!rst) begin
      m_known   = 1'b1;
      m_started = 1'b0;
      m_pc      = 16'h0000;
      m_valid   = 1'b0;
      m_instr   = 16'h0000;
      m_ipc     = 16'h0000;
      m_jmp     = 1'b0;
    end else if (m_known) begin
      if (!m_started) begin
        m_started = 1'b1;
      end else if (redir) begin
        m_pc    = rpc;
        m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        w       = rom_word(m_pc);
        m_instr = w;
        m_ipc   = m_pc;
        m_jmp   = (w[15:12] == 4'hE);
        m_valid = 1'b1;
        m_pc    = m_jmp ? {4'h0, w[11:0]} : m_pc + 16'd1;
      end
    end
  endtask

  // One clock of stimulus; records the instruction decode takes at this edge.
  task automatic cycle(input logic rst, input logic rdy, input logic redir,
                       input logic [15:0] rpc);
    rst_n          = rst;
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rst && rdy && !redir && if_valid === 1'b1) acc_q.push_back(if_pc);
    @(posedge clk);
    model_step(rst, rdy, redir, rpc);
    #1;
    $display("t=%0t rst_n=%b rdy=%b redir=%b -> valid=%b pc=%h instr=%h jmp=%b addr=%h oe=%b",
             $time, rst, rdy, redir, if_valid, if_pc, if_instr, if_jmp_taken, rom_addr, rom_oe);
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk_b("cyc_valid", if_valid, m_valid);
      chk_b("cyc_rom_oe", rom_oe, m_started);
      chk("cyc_rom_addr", rom_addr, m_pc);
      if (m_valid || !m_started) begin
        chk("cyc_instr", if_instr, m_instr);
        chk("cyc_pc", if_pc, m_ipc);
        chk_b("cyc_jmp", if_jmp_taken, m_jmp);
      end
    end
  end

  logic [15:0] exp_acc [21] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009,
                                16'h0004, 16'h0005, 16'h0006, 16'h0014, 16'h0015,
                                16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001,
                                16'h0002};

  initial begin
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_b("rst_valid", if_valid, 1'b0);
    chk_b("rst_oe", rom_oe, 1'b0);
    chk("rst_addr", rom_addr, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);

    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_b("warm_valid", if_valid, 1'b0);
    chk_b("warm_oe", rom_oe, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_b("first_valid", if_valid, 1'b1);
    chk("first_pc", if_pc, 16'h0000);
    chk("first_instr", if_instr, 16'h1000);

    repeat (9) cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("jmp_pc", if_pc, 16'h0009);
    chk("jmp_instr", if_instr, 16'hE004);
    chk_b("jmp_taken", if_jmp_taken, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("jmp_target_pc", if_pc, 16'h0004);
    chk_b("jmp_target_flag", if_jmp_taken, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("pre_hold_pc", if_pc, 16'h0005);

    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("hold_pc", if_pc, 16'h0005);
      chk("hold_instr", if_instr, 16'h1005);
      chk("hold_addr", rom_addr, 16'h0006);
    end
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("release_pc", if_pc, 16'h0006);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("hold2_pc", if_pc, 16'h0007);

    cycle(1'b1, 1'b0, 1'b1, 16'h0014);
    chk_b("redir_valid", if_valid, 1'b0);
    chk("redir_addr", rom_addr, 16'h0014);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_b("redir_target_valid", if_valid, 1'b1);
    chk("redir_target_pc", if_pc, 16'h0014);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 16'h0000);

    cycle(1'b1, 1'b1, 1'b1, 16'hFFFE);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("top_pc", if_pc, 16'hFFFF);
    chk("top_instr", if_instr, 16'h1FFF);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pc", if_pc, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);

    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_b("mid_rst_valid", if_valid, 1'b0);
    chk("mid_rst_pc", if_pc, 16'h0000);
    chk("mid_rst_instr", if_instr, 16'h0000);
    chk_b("mid_rst_jmp", if_jmp_taken, 1'b0);
    chk_b("mid_rst_oe", rom_oe, 1'b0);
    chk("mid_rst_addr", rom_addr, 16'h0000);

    cycle(1'b1, 1'b1, 1'b1, 16'h0030);
    chk_b("idle_redir_valid", if_valid, 1'b0);
    chk("idle_redir_addr", rom_addr, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk_b("restart_valid", if_valid, 1'b1);
    chk("restart_pc", if_pc, 16'h0000);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 16'h0000);

    chk("acc_count", 16'(acc_q.size()), 16'd21);
    for (int i = 0; i < 21; i++) begin
      if (i < acc_q.size()) chk($sformatf("acc_%0d", i), acc_q[i], exp_acc[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
